ksa_shuffle_param: RTL
======================

Name: ksa_shuffle_param

Overview:
Parametrised RC4 key-scheduling shuffle engine, the successor to the fixed 256-entry, 3-byte-key shuffler. It drives a single-port synchronous S-array RAM and runs the full KSA swap loop over 2^ADDR_WIDTH entries. Key length is selectable at run time, up to KEY_BYTES, and RAM read latency is configurable. It sits between the init (S[i]=i) stage and the decrypt/PRGA stage of the cracking datapath. It is re-startable from DONE without reset.

Parameters:
ADDR_WIDTH, 8, log2 of S-array depth; legal range 4..8; S data width equals ADDR_WIDTH.
KEY_BYTES, 3, maximum key length in bytes; legal range 1..16.
RD_LATENCY, 1, RAM read latency in cycles (address to q); legal range 1..3.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  level; sampled only in IDLE or DONE.
secret  input  KEY_BYTES*8  key; byte k = secret[(KEY_BYTES-1-k)*8 +: 8], so byte 0 is the MSB byte.
key_len  input  5  active key bytes; 0 or >KEY_BYTES means KEY_BYTES.
address  output  ADDR_WIDTH  RAM address.
data  output  ADDR_WIDTH  RAM write data.
wren  output  1  RAM write enable.
q  input  ADDR_WIDTH  RAM read data.
busy  output  1  high from start accept until finish.
finish  output  1  high and held in DONE.

Behaviour:
- Reset: address=0, data=0, wren=0, busy=0, finish=0; i=j=kidx=0; state=IDLE. Reset mid-run aborts the loop; wren is 0 from the next cycle. RAM contents are left as they are.
- All outputs are registered.
- key_len, secret and start are latched on start accept. Later changes do not affect the run in progress.
- start is ignored while busy.
- States:
  - IDLE/DONE --start--> RD_I. On accept: i=0, j=0, kidx=0, finish=0, busy=1.
  - RD_I: address=i, wren=0; lasts RD_LATENCY cycles.
  - CALC_J: latch si=q. Compute jn = (j + si + keybyte[kidx][ADDR_WIDTH-1:0]) mod 2^ADDR_WIDTH. Set j=jn and address=jn. Lasts 1 cycle.
  - RD_J: address=j; lasts RD_LATENCY cycles.
  - WR_J: latch sj=q. Drive address=j, data=si, wren=1.
  - WR_I: address=i, data=sj, wren=1.
  - WR_I advance, i < 2^ADDR_WIDTH-1: i++, kidx = (kidx==len-1) ? 0 : kidx+1, go to RD_I. kidx is a rolling counter; no divider.
  - WR_I advance, i == 2^ADDR_WIDTH-1: go to DONE with wren=0, busy=0, finish=1.
- Cycles per iteration: 2*RD_LATENCY+3.
- finish rises exactly 2^ADDR_WIDTH*(2*RD_LATENCY+3)+1 cycles after the start-accept edge. For ADDR_WIDTH=8, RD_LATENCY=1 this is 1281.
- i==j: both writes target the same address with the same value; the net result is no change. Both reads complete before either write, so there is no read-after-write hazard within an iteration.
- Arithmetic wraps modulo 2^ADDR_WIDTH. Key bytes are truncated to their low ADDR_WIDTH bits.
- DONE holds finish=1 and wren=0 until start (restart) or rst.

Optional Feature:
KSA_INIT_PHASE_EN:
- Defined: on start accept, first run an INIT state that writes S[n]=n for n=0..2^ADDR_WIDTH-1. Each write is one cycle with wren=1. The shuffle then begins from RD_I with i=j=0. finish latency grows by 2^ADDR_WIDTH cycles, giving 1537 for the default parameters.
- Undefined: there is no INIT state; the S-array must be pre-initialised externally.

Test Plan:
- Defaults, RAM preloaded with identity, secret=24'h000249, key_len=3 -> final RAM equals the software KSA model; finish at cycle 1281; first write pair is addr 0 data 0 then addr 0 data 0 (j=0).
- key_len=1, secret=24'h01xxxx, identity RAM -> iteration 0 writes S[1]=0 then S[0]=1 (j=1); final RAM matches the model using the 1-byte key 0x01.
- key_len=0 and key_len=9 with KEY_BYTES=3 -> results identical to key_len=3 for the same secret.
- RD_LATENCY=2, ADDR_WIDTH=4, identity RAM -> finish at cycle 16*7+1=113; final 16-entry array matches the model; wren is never 1 in RD_I or RD_J.
- rst asserted mid-run at iteration 37 -> next cycle wren=0, busy=0, finish=0. A new start with an identity reload then yields a correct result; start pulses while busy are ignored (no restart, same finish cycle).
- With KSA_INIT_PHASE_EN and garbage RAM, default parameters -> first 256 cycles write n to address n; final array and finish at 1537 match the model.

Source files
------------

// File: rtl/ksa_shuffle_param.sv
// ksa_shuffle_param: RC4 key-scheduling swap loop over a 2^ADDR_WIDTH single-port S RAM.
// Define KSA_INIT_PHASE_EN to write S[n]=n before the shuffle starts.
module ksa_shuffle_param #(
    parameter int ADDR_WIDTH = 8,
    parameter int KEY_BYTES  = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] secret,
    input  logic [4:0]             key_len,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic [ADDR_WIDTH-1:0]  data,
    output logic                   wren,
    input  logic [ADDR_WIDTH-1:0]  q,
    output logic                   busy,
    output logic                   finish
);
    localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [1:0] WMAX = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, INIT, RD_I, CALC_J, RD_J, WR_J, WR_I, DONE} state_t;

    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] i, i_n, j, j_n, si, si_n, address_n, data_n;
    logic [ADDR_WIDTH-1:0] kb [KEY_BYTES];
    logic [ADDR_WIDTH-1:0] kb_n [KEY_BYTES];
    logic [KW-1:0] kidx, kidx_n, len_m1, len_m1_n;
    logic [1:0] wcnt, wcnt_n;
    logic wren_n, busy_n, finish_n;

    // Every output is computed one cycle ahead and registered; q is consumed on the exit edge of CALC_J / WR_J.
    always_comb begin
        state_n = state;
        i_n = i;
        j_n = j;
        kidx_n = kidx;
        len_m1_n = len_m1;
        si_n = si;
        wcnt_n = wcnt;
        address_n = address;
        data_n = data;
        wren_n = 1'b0;
        busy_n = busy;
        finish_n = finish;
        for (int k = 0; k < KEY_BYTES; k++) kb_n[k] = kb[k];
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    for (int k = 0; k < KEY_BYTES; k++) kb_n[k] = secret[(KEY_BYTES-1-k)*8 +: ADDR_WIDTH];
                    len_m1_n = (key_len == 5'd0 || key_len > 5'(KEY_BYTES)) ? KW'(KEY_BYTES - 1) : KW'(key_len - 5'd1);
                    i_n = '0;
                    j_n = '0;
                    kidx_n = '0;
                    wcnt_n = '0;
                    address_n = '0;
                    busy_n = 1'b1;
                    finish_n = 1'b0;
`ifdef KSA_INIT_PHASE_EN
                    data_n = '0;
                    wren_n = 1'b1;
                    state_n = INIT;
`else
                    state_n = RD_I;
`endif
                end
            end
`ifdef KSA_INIT_PHASE_EN
            INIT: begin
                i_n = (i == LAST) ? '0 : i + 1'b1;
                address_n = (i == LAST) ? '0 : i + 1'b1;
                data_n = i + 1'b1;
                wren_n = (i != LAST);
                state_n = (i == LAST) ? RD_I : INIT;
            end
`endif
            RD_I: begin
                wcnt_n = (wcnt == WMAX) ? '0 : wcnt + 1'b1;
                state_n = (wcnt == WMAX) ? CALC_J : RD_I;
            end
            CALC_J: begin
                si_n = q;
                j_n = j + q + kb[kidx];
                address_n = j + q + kb[kidx];
                state_n = RD_J;
            end
            RD_J: begin
                wcnt_n = (wcnt == WMAX) ? '0 : wcnt + 1'b1;
                state_n = (wcnt == WMAX) ? WR_J : RD_J;
                data_n = (wcnt == WMAX) ? si : data;
                wren_n = (wcnt == WMAX);
            end
            WR_J: begin
                address_n = i;
                data_n = q;
                wren_n = 1'b1;
                state_n = WR_I;
            end
            WR_I: begin
                if (i == LAST) begin
                    busy_n = 1'b0;
                    finish_n = 1'b1;
                    state_n = DONE;
                end else begin
                    i_n = i + 1'b1;
                    address_n = i + 1'b1;
                    kidx_n = (kidx == len_m1) ? '0 : kidx + 1'b1;
                    state_n = RD_I;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i <= '0;
            j <= '0;
            kidx <= '0;
            len_m1 <= '0;
            si <= '0;
            wcnt <= '0;
            address <= '0;
            data <= '0;
            wren <= 1'b0;
            busy <= 1'b0;
            finish <= 1'b0;
        end else begin
            state <= state_n;
            i <= i_n;
            j <= j_n;
            kidx <= kidx_n;
            len_m1 <= len_m1_n;
            si <= si_n;
            wcnt <= wcnt_n;
            address <= address_n;
            data <= data_n;
            wren <= wren_n;
            busy <= busy_n;
            finish <= finish_n;
        end
    end

    always_ff @(posedge clk) begin
        kb <= kb_n;
    end
endmodule
